multicycle_control_unit: RTL

- Multi-cycle controller that sequences the RISC-V datapath unit.
- Latches the 3-bit Opcode the datapath returns, walks a FETCH/DECODE/EXEC/MEM/WB state machine, and drives the datapath control strobes plus a PC-enable.
- Handles a ready-handshake with data memory, including a timeout.
- Exposes run/halt/error status and performance counters to the top level.

---
 rtl/multicycle_control_unit_pkg.sv | 31 +++
 rtl/multicycle_control_unit_if.sv | 24 ++
 rtl/multicycle_control_unit_ctrl_decoder.sv | 32 +++
 rtl/multicycle_control_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types for the multicycle RISC-V controller: opcodes, ALU selects and FSM states.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LD   = 3'b000,
    OP_SD   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERR    = 3'd7
  } state_e;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath / data-memory bundle: opcode, flags, ready handshake and control strobes.
interface multicycle_control_unit_if;
  logic [2:0] Opcode;
  logic       z;
  logic       mem_ready;
  logic       beq;
  logic       mem_read;
  logic       mem_write;
  logic       alu_src;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_op;
  logic       pc_en;

  modport master (
    input  Opcode, z, mem_ready,
    output beq, mem_read, mem_write, alu_src, mem_to_reg, reg_write, alu_op, pc_en
  );

  modport slave (
    output Opcode, z, mem_ready,
    input  beq, mem_read, mem_write, alu_src, mem_to_reg, reg_write, alu_op, pc_en
  );
endinterface

// File: rtl/multicycle_control_unit_ctrl_decoder.sv
// Combinational classification of the latched opcode, shared by the EXEC, MEM and WB states.
module ctrl_decoder
  import riscv_ctrl_pkg::*;
(
  input  opcode_e    op,
  output logic       is_mem,
  output logic       is_ld,
  output logic       is_rtype,
  output logic       is_beq,
  output logic [1:0] alu_op
);

  // Opcode class and ALU select lookup
  always_comb begin
    is_mem   = 1'b0;
    is_ld    = 1'b0;
    is_rtype = 1'b0;
    is_beq   = 1'b0;
    alu_op   = ALU_ADD;
    case (op)
      OP_LD:   begin is_mem = 1'b1; is_ld = 1'b1; end
      OP_SD:   is_mem = 1'b1;
      OP_ADD:  begin is_rtype = 1'b1; alu_op = ALU_ADD; end
      OP_SUB:  begin is_rtype = 1'b1; alu_op = ALU_SUB; end
      OP_AND:  begin is_rtype = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin is_rtype = 1'b1; alu_op = ALU_OR;  end
      OP_BEQ:  begin is_beq = 1'b1; alu_op = ALU_SUB; end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready timeout and saturating
// busy-cycle / retired-instruction counters.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  multicycle_control_unit_if.master dp,
  output logic                      busy,
  output logic                      halted,
  output logic                      err,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          instr_count
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  opcode_e             op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d, ins_q, ins_d;

  logic       is_mem_s, is_ld_s, is_rtype_s, is_beq_s;
  logic [1:0] dec_alu_op_s;
  logic       beq_s, mem_read_s, mem_write_s, alu_src_s, mem_to_reg_s, reg_write_s, pc_en_s;
  logic [1:0] alu_op_s;
  logic       busy_s;

  ctrl_decoder u_dec (
    .op       (op_q),
    .is_mem   (is_mem_s),
    .is_ld    (is_ld_s),
    .is_rtype (is_rtype_s),
    .is_beq   (is_beq_s),
    .alu_op   (dec_alu_op_s)
  );

  // State, latched opcode, MEM wait counter and performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_LD;
      wait_q  <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  // Next-state and Moore strobes; mem_write/pc_en in MEM also follow mem_ready
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_d       = wait_q;
    beq_s        = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    alu_src_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_op_s     = ALU_ADD;
    pc_en_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
        else       state_d = IDLE;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        op_d = opcode_e'(dp.Opcode);
        if (op_d == OP_HALT) state_d = HALT;
        else                 state_d = EXEC;
      end
      EXEC: begin
        alu_src_s = is_mem_s;
        alu_op_s  = dec_alu_op_s;
        if (is_beq_s) begin
          beq_s   = 1'b1;
          pc_en_s = 1'b1;
          state_d = FETCH;
        end else if (is_mem_s) begin
          wait_d  = '0;
          state_d = MEM;
        end else if (is_rtype_s) begin
          state_d = WB;
        end else begin
          state_d = ERR;
        end
      end
      MEM: begin
        alu_src_s  = 1'b1;
        alu_op_s   = dec_alu_op_s;
        mem_read_s = is_ld_s;
        if (dp.mem_ready) begin
          if (is_ld_s) begin
            state_d = WB;
          end else begin
            mem_write_s = 1'b1;
            pc_en_s     = 1'b1;
            state_d     = FETCH;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_LAST) state_d = ERR;
          else                     state_d = MEM;
        end
      end
      WB: begin
        reg_write_s = 1'b1;
        pc_en_s     = 1'b1;
        state_d     = FETCH;
        if (is_ld_s) begin
          mem_to_reg_s = 1'b1;
          mem_read_s   = 1'b1;
          alu_src_s    = 1'b1;
          alu_op_s     = ALU_ADD;
        end else begin
          alu_op_s     = dec_alu_op_s;
        end
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // Status flags and saturating counter updates
  always_comb begin
    busy_s = (state_q != IDLE) && (state_q != HALT) && (state_q != ERR);
    if (busy_s && (cyc_q != CNT_MAX)) cyc_d = cyc_q + CNT_W'(1);
    else                              cyc_d = cyc_q;
    if (pc_en_s && (ins_q != CNT_MAX)) ins_d = ins_q + CNT_W'(1);
    else                               ins_d = ins_q;
  end

  assign dp.beq        = beq_s;
  assign dp.mem_read   = mem_read_s;
  assign dp.mem_write  = mem_write_s;
  assign dp.alu_src    = alu_src_s;
  assign dp.mem_to_reg = mem_to_reg_s;
  assign dp.reg_write  = reg_write_s;
  assign dp.alu_op     = alu_op_s;
  assign dp.pc_en      = pc_en_s;
  assign busy          = busy_s;
  assign halted        = (state_q == HALT);
  assign err           = (state_q == ERR);
  assign cycle_count   = cyc_q;
  assign instr_count   = ins_q;

endmodule
